// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// zero-register index, ABI register names and a small range helper.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_NRD   = 2;

    localparam int REG_ZERO  = 0;

    // ABI register indices used by decode and benches
    localparam int REG_RA = 1;
    localparam int REG_SP = 2;
    localparam int REG_GP = 3;
    localparam int REG_TP = 4;
    localparam int REG_T0 = 5;
    localparam int REG_T1 = 6;
    localparam int REG_T2 = 7;
    localparam int REG_S0 = 8;
    localparam int REG_S1 = 9;
    localparam int REG_A0 = 10;
    localparam int REG_A1 = 11;

    // True when an address names an implemented register
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned nregs);
        return addr < nregs;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW,
    parameter int NRD   = DEF_NRD
);
    logic                 we;
    logic [AW-1:0]        wa;
    logic [XLEN-1:0]      wd;
    logic [NRD*AW-1:0]    ra;
    logic [NRD*XLEN-1:0]  rd;
    logic                 sb_set;
    logic [AW-1:0]        sb_addr;
    logic [NRD-1:0]       rd_busy;
    logic [NREGS-1:0]     busy;

    modport master (
        output we, wa, wd, ra, sb_set, sb_addr,
        input  rd, rd_busy, busy
    );

    modport slave (
        input  we, wa, wd, ra, sb_set, sb_addr,
        output rd, rd_busy, busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy flags for hazard detection. Issue sets, writeback
// clears; a same-cycle set and clear of one register leaves it busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set,
    input  logic [AW-1:0]    i_set_addr,
    input  logic             i_clr,
    input  logic [AW-1:0]    i_clr_addr,
    output logic [NREGS-1:0] o_busy
);

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        if (ZERO_REG != 0 && gi == REG_ZERO) begin : g_zero
            assign o_busy[gi] = 1'b0;
        end else begin : g_bit
            logic r_busy;
            // Set has priority over clear: a newer producer was issued this cycle
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_busy <= 1'b0;
                end else if (i_set && i_set_addr == AW'(gi)) begin
                    r_busy <= 1'b1;
                end else if (i_clr && i_clr_addr == AW'(gi)) begin
                    r_busy <= 1'b0;
                end
            end
            assign o_busy[gi] = r_busy;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with asynchronous clear, optional hardwired
// zero register, optional write-to-read bypass and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int AW       = DEF_AW,
    parameter int NRD      = DEF_NRD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    logic [XLEN-1:0]  w_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (ZERO_REG != 0 && gi == REG_ZERO) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [XLEN-1:0] r_q;
            // Capture write data when addressed; cleared asynchronously by reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (bus.we && bus.wa == AW'(gi)) begin
                    r_q <= bus.wd;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set      (bus.sb_set),
        .i_set_addr (bus.sb_addr),
        .i_clr      (bus.we),
        .i_clr_addr (bus.wa),
        .o_busy     (w_busy)
    );

    assign bus.busy = w_busy;

    // Combinational read per port; reset gating keeps a bypassed write from
    // leaking through while the file is held in reset
    always_comb begin
        logic [AW-1:0] w_ra;
        w_ra        = '0;
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            w_ra = bus.ra[p*AW +: AW];
            if (rst && addr_in_range(32'(w_ra), NREGS) &&
                !(ZERO_REG != 0 && w_ra == '0)) begin
                if (BYPASS != 0 && bus.we && bus.wa == w_ra) begin
                    // result arrives this cycle, so the operand is not busy
                    bus.rd[p*XLEN +: XLEN] = bus.wd;
                end else begin
                    bus.rd[p*XLEN +: XLEN] = w_regs[w_ra];
                    bus.rd_busy[p]         = w_busy[w_ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three instances (default, no bypass,
// 24 registers) share one stimulus stream; expectations go through a queue.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic        sb_set;
    logic [4:0]  sb_addr;

    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2)) if_a ();
    regfile_mp_if #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2)) if_b ();
    regfile_mp_if #(.XLEN(32), .NREGS(24), .AW(5), .NRD(2)) if_c ();

    assign if_a.we = we;  assign if_a.wa = wa;  assign if_a.wd = wd;
    assign if_a.ra = ra;  assign if_a.sb_set = sb_set;  assign if_a.sb_addr = sb_addr;
    assign if_b.we = we;  assign if_b.wa = wa;  assign if_b.wd = wd;
    assign if_b.ra = ra;  assign if_b.sb_set = sb_set;  assign if_b.sb_addr = sb_addr;
    assign if_c.we = we;  assign if_c.wa = wa;  assign if_c.wd = wd;
    assign if_c.ra = ra;  assign if_c.sb_set = sb_set;  assign if_c.sb_addr = sb_addr;

    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2), .BYPASS(0), .ZERO_REG(1))
        u_b (.clk(clk), .rst(rst), .bus(if_b));
    regfile_mp #(.XLEN(32), .NREGS(24), .AW(5), .NRD(2), .BYPASS(1), .ZERO_REG(1))
        u_c (.clk(clk), .rst(rst), .bus(if_c));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_underflow observed=%h required=none", obs);
            return;
        end
        e = exp_q.pop_front();
        $display("check %-14s observed=%h required=%h", e.tag, obs, e.val);
        assert (obs === e.val)
        else begin
            errors++;
            $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; sb_set = 1'b0; sb_addr = '0;
    endtask

    initial begin
        // reset held with a live write/bypass request on the bus
        rst = 1'b0; idle();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd5, 5'd5};
        sb_set = 1'b1; sb_addr = 5'd5;
        push("rst_rd0", 32'h0); push("rst_rdbusy", 32'h0); push("rst_busy", 32'h0);
        @(negedge clk); #1;
        pop_check(if_a.rd[31:0]);
        pop_check({30'b0, if_a.rd_busy});
        pop_check(if_a.busy);

        // release, then write reg 5
        @(negedge clk);
        rst = 1'b1; idle();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd0};
        push("wr5", 32'hDEADBEEF);
        @(negedge clk);
        idle(); ra = {5'd0, 5'd5};
        #1 pop_check(if_a.rd[31:0]);

        // asynchronous clear between edges, write during reset is lost
        rst = 1'b0;
        push("async_clr", 32'h0);
        #1 pop_check(if_a.rd[31:0]);
        we = 1'b1; wa = 5'd5; wd = 32'h55;
        repeat (2) @(negedge clk);
        rst = 1'b1; idle();
        push("post_rst_r5", 32'h0); push("post_rst_busy", 32'h0); push("post_rst_rdb", 32'h0);
        #1;
        pop_check(if_a.rd[31:0]);
        pop_check(if_a.busy);
        pop_check({30'b0, if_a.rd_busy});

        // plain write then dual-port read of the same register
        @(negedge clk);
        we = 1'b1; wa = 5'd9; wd = 32'h36; ra = {5'd0, 5'd0};
        push("rd9_p0", 32'h36); push("rd9_p1", 32'h36); push("rd9_nb", 32'h36); push("rd9_busy", 32'h0);
        @(negedge clk);
        idle(); ra = {5'd9, 5'd9};
        #1;
        pop_check(if_a.rd[31:0]);
        pop_check(if_a.rd[63:32]);
        pop_check(if_b.rd[31:0]);
        pop_check(if_a.busy);

        // zero register ignores writes and issue
        @(negedge clk);
        we = 1'b1; wa = 5'd0; wd = 32'h1234; sb_set = 1'b1; sb_addr = 5'd0; ra = {5'd0, 5'd0};
        push("zero_byp", 32'h0); push("zero_rd", 32'h0); push("zero_busy", 32'h0);
        #1 pop_check(if_a.rd[31:0]);
        @(negedge clk);
        idle();
        #1;
        pop_check(if_a.rd[31:0]);
        pop_check(if_a.busy);

        // bypass versus stored value on reg 7
        @(negedge clk);
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd0, 5'd7};
        push("byp_on", 32'hA5A5A5A5); push("byp_off", 32'h0); push("byp_off_st", 32'hA5A5A5A5);
        #1;
        pop_check(if_a.rd[31:0]);
        pop_check(if_b.rd[31:0]);
        @(negedge clk);
        idle();
        #1 pop_check(if_b.rd[31:0]);

        // scoreboard: issue reg 3, then writeback clears it
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd3; ra = {5'd0, 5'd3};
        push("sb3_busy", 32'h8); push("sb3_rdb", 32'h1); push("sb3_rdb_nb", 32'h1);
        @(negedge clk);
        idle();
        #1;
        pop_check(if_a.busy);
        pop_check({30'b0, if_a.rd_busy});
        pop_check({30'b0, if_b.rd_busy});
        we = 1'b1; wa = 5'd3; wd = 32'h77;
        push("wb3_rdb", 32'h0); push("wb3_rdb_nb", 32'h1); push("wb3_busy", 32'h8);
        #1;
        pop_check({30'b0, if_a.rd_busy});
        pop_check({30'b0, if_b.rd_busy});
        pop_check(if_a.busy);
        push("wb3_clr", 32'h0); push("wb3_data", 32'h77);
        @(negedge clk);
        idle();
        #1;
        pop_check(if_a.busy);
        pop_check(if_a.rd[31:0]);

        // simultaneous issue and writeback to reg 4: set wins
        @(negedge clk);
        sb_set = 1'b1; sb_addr = 5'd4; we = 1'b1; wa = 5'd4; wd = 32'h44; ra = {5'd4, 5'd3};
        push("both4_busy", 32'h10); push("both4_rdb", 32'h2); push("both4_data", 32'h44);
        @(negedge clk);
        idle();
        #1;
        pop_check(if_a.busy);
        pop_check({30'b0, if_a.rd_busy});
        pop_check(if_a.rd[63:32]);

        // out-of-range address on the 24-register instance
        @(negedge clk);
        we = 1'b1; wa = 5'd30; wd = 32'hFFFF; sb_set = 1'b1; sb_addr = 5'd30; ra = {5'd9, 5'd30};
        push("oor_byp", 32'h0); push("oor_rdb", 32'h0);
        #1;
        pop_check(if_c.rd[31:0]);
        pop_check({30'b0, if_c.rd_busy});
        push("oor_rd", 32'h0); push("oor_busy", 32'h10); push("oor_r9", 32'h36);
        push("in_rng_busy", 32'h40000010); push("in_rng_rd", 32'hFFFF);
        @(negedge clk);
        idle();
        #1;
        pop_check(if_c.rd[31:0]);
        pop_check({8'h0, if_c.busy});
        pop_check(if_c.rd[63:32]);
        pop_check(if_a.busy);
        pop_check(if_a.rd[31:0]);

        // every pushed expectation must have been consumed
        checks++;
        assert (exp_q.size() == 0)
        else begin
            errors++;
            $error("FAIL queue_leftover observed=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the next-generation core.
- Adds the following over the single-cycle register file:
  - asynchronous clear of all registers;
  - hardwired zero register;
  - optional write-to-read bypass;
  - per-register busy scoreboard that a pipelined datapath uses for hazard detection.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; need not be a power of two.
- AW, 5, register address width; must satisfy 2**AW >= NREGS.
- NRD, 2, number of independent read ports.
- BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = read returns the stored value only.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- ra  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd  out  NRD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- sb_set  in  1  issue strobe: mark register sb_addr busy.
- sb_addr  in  AW  destination register of the issuing instruction.
- rd_busy  out  NRD  per-port flag: the read operand is not yet valid.
- busy  out  NREGS  raw scoreboard vector for debug and stall logic.

Behaviour:
- Reset (rst=0, asynchronous): all registers are 0 and busy is all 0 immediately, independent of clk.
  - While rst=0, rd is 0 and rd_busy is 0 on every port.
  - When rst is released, the next rising clk edge is the first edge that samples we or sb_set.
- Write:
  - On a rising clk with we=1, reg[wa] <= wd.
  - The write is ignored if wa >= NREGS.
  - The write is ignored if ZERO_REG=1 and wa=0.
- Read: combinational, zero latency. For each port i:
  - rd_i = 0 if ra_i >= NREGS;
  - else rd_i = 0 if ZERO_REG=1 and ra_i=0;
  - else rd_i = wd if BYPASS=1, we=1 and wa=ra_i;
  - otherwise rd_i = reg[ra_i].
- Two ports may read the same address; both return the same value.
- Scoreboard, updated on the rising clk edge:
  - sb_set=1 sets busy[sb_addr].
  - we=1 clears busy[wa].
  - sb_set=1 and we=1 to the same address in the same cycle: set wins, because a newer producer was issued.
  - Addresses >= NREGS are ignored.
  - When ZERO_REG=1, busy[0] is held at 0.
  - Setting an already-busy register leaves it busy. There is no counting; the core guarantees at most one outstanding producer per register.
- rd_busy_i:
  - rd_busy_i = busy[ra_i], except rd_busy_i = 0 when BYPASS=1, we=1 and wa=ra_i (the result arrives this cycle).
  - rd_busy_i is 0 for out-of-range addresses and for the zero register.
- Write with we=1 to a non-busy register: the data is written and busy stays 0. This is a legal writeback without a scoreboard entry.
- Reset asserted mid-operation: registers and busy clear asynchronously; any in-flight write that edge is lost.
- No initial-block preloading; software initialises registers.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN, NREGS, AW;
  - constant REG_ZERO = 0;
  - localparams for the ABI register indices (ra=1, sp=2, ...) used by benches and decode.
- Sub-module regfile_scoreboard, parametrised by NREGS, AW and ZERO_REG:
  - owns the busy vector and its set/clear priority;
  - regfile_mp instantiates it and adds the bypass masking of rd_busy.

Test Plan:
- Hold rst=0 for 2 cycles after writing 0xDEADBEEF to reg 5, then release -> reg 5 reads 0; busy=0; rd_busy=0.
- Write wd=0x36 with wa=9, then read ra0=9, ra1=9 -> both ports return 0x00000036 one cycle later.
- Write 0x1234 to reg 0 with ZERO_REG=1 -> reg 0 reads 0; busy[0] stays 0 after sb_set with sb_addr=0.
- Bypass: we=1, wa=7, wd=0xA5A5A5A5, ra0=7 in the same cycle -> with BYPASS=1, rd0=0xA5A5A5A5 before the edge; with BYPASS=0, rd0 holds the old value (0).
- Scoreboard: sb_set reg 3 -> busy[3]=1 and rd_busy for ra=3 is 1. Next cycle we with wa=3 -> rd_busy=0 combinationally, then busy[3]=0 after the edge. Simultaneous sb_set and we to reg 4 -> busy[4]=1.
- NREGS=24: write wa=30 and read ra=30 -> rd=0, no register changes, busy unchanged.
